// File: rtl/systolic_skew_feeder_if.sv
// Row-in / skewed-lanes-out bus of the systolic skew feeder.
// The master drives rows and the stall request; the slave (the feeder) returns the skewed lanes.
interface systolic_skew_feeder_if #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
);
  logic           in_valid;
  logic [N*W-1:0] in_data;
  logic           in_last;
  logic           in_ready;
  logic           stall;
  logic [N*W-1:0] out_data;
  logic [N-1:0]   out_valid;
  logic           out_done;

  modport master (
    output in_valid, in_data, in_last, stall,
    input  in_ready, out_data, out_valid, out_done
  );

  modport slave (
    input  in_valid, in_data, in_last, stall,
    output in_ready, out_data, out_valid, out_done
  );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Systolic array skew feeder: lane i delays its element of each accepted row by i+1 registers,
// so a row leaves as a diagonal wavefront. A small FSM tracks matrix boundaries and pulses
// out_done when the last row's element appears on lane N-1.
module systolic_skew_feeder #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
) (
  input logic                     i_clk,
  input logic                     i_rst_n,
  systolic_skew_feeder_if.slave   io_bus
);

  localparam int unsigned CntW = $clog2(N);
  // The drain counter counts 0..N-2; the (N-1)th non-stalled DRAIN edge returns to IDLE.
  localparam logic [CntW-1:0] CntLast = CntW'(N - 2);

  typedef enum logic [1:0] {StIdle, StStream, StDrain} state_e;

  state_e          r_state;
  state_e          w_state_nxt;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_nxt;
  logic            r_done;
  logic            w_done_nxt;
  logic            w_in_ready;
  logic            w_accept;

  // Reset is folded in so in_ready reads 0 while the block is held in reset.
  assign w_in_ready      = i_rst_n && !io_bus.stall && (r_state != StDrain);
  assign w_accept        = io_bus.in_valid && w_in_ready;
  assign io_bus.in_ready = w_in_ready;
  assign io_bus.out_done = r_done;

  // Per-lane delay lines; a bubble (data 0, valid 0) enters on every non-stalled idle edge.
  for (genvar g = 0; g < N; g++) begin : g_lane
    logic [W-1:0] r_data [0:g];
    logic         r_vld  [0:g];

    // Shift the lane one stage per non-stalled edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        for (int k = 0; k <= g; k++) begin
          r_data[k] <= '0;
          r_vld[k]  <= 1'b0;
        end
      end else if (!io_bus.stall) begin
        r_data[0] <= w_accept ? io_bus.in_data[g*W +: W] : '0;
        r_vld[0]  <= w_accept;
        for (int k = 1; k <= g; k++) begin
          r_data[k] <= r_data[k-1];
          r_vld[k]  <= r_vld[k-1];
        end
      end
    end

    assign io_bus.out_data[g*W +: W] = r_data[g];
    assign io_bus.out_valid[g]       = r_vld[g];
  end

  // Next-state: matrix framing and drain countdown until the last row clears lane N-1.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      StIdle, StStream: begin
        if (w_accept) begin
          w_state_nxt = io_bus.in_last ? StDrain : StStream;
        end
      end
      StDrain: begin
        if (r_cnt == CntLast) begin
          w_state_nxt = StIdle;
          w_cnt_nxt   = '0;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CntW'(1);
        end
      end
      default: begin
        w_state_nxt = StIdle;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Control registers; a stall freezes them along with the lanes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else if (!io_bus.stall) begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
    end
  end

endmodule
